// File: rtl/cc1200_reg_access.sv
// CC1200 register-access sequencer: turns one host request into a header/address/data SPI
// frame for the byte-level engine and returns the chip status byte and read data.
module cc1200_reg_access #(
  parameter int unsigned LenW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_write_i,
  input  logic            req_ext_i,
  input  logic [7:0]      req_addr_i,
  input  logic [LenW-1:0] req_len_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_valid_i,
  output logic            wr_take_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_valid_o,
  output logic [7:0]      status_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            err_underrun_o,
  output logic            spi_start_o,
  output logic            spi_stop_o,
  output logic [7:0]      spi_dout_o,
  input  logic            spi_load_next_i,
  input  logic [7:0]      spi_din_i,
  input  logic            spi_busy_i
);

  // One extra bit: the last byte index can reach 1 + 2^LenW - 1.
  localparam int unsigned IdxW = LenW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StCapt, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] k_q, k_d;
  logic [IdxW-1:0] last_q, last_d;
  logic            write_q, write_d;
  logic            ext_q, ext_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic            stop_q, stop_d;
  logic            under_q, under_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic [7:0]      status_q, status_d;
  logic            done_q, done_d;

  logic [IdxW-1:0] nxt_idx;
  logic [IdxW-1:0] data_first;
  logic [7:0]      nxt_byte;
  logic            nxt_take;
  logic            nxt_under;
  logic            take;

  assign data_first = IdxW'(ext_q) + IdxW'(1);
  assign nxt_idx    = (state_q == StStart) ? IdxW'(1) : k_q + IdxW'(2);

  // Byte that would be loaded into spi_dout now; write data is fetched only when it exists.
  always_comb begin
    nxt_byte  = 8'h00;
    nxt_take  = 1'b0;
    nxt_under = 1'b0;
    if (nxt_idx <= last_q) begin
      if (nxt_idx < data_first) begin
        nxt_byte = addr_q;
      end else if (write_q) begin
        if (wr_valid_i) begin
          nxt_byte = wr_data_i;
          nxt_take = 1'b1;
        end else begin
          nxt_under = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    last_d     = last_q;
    write_d    = write_q;
    ext_d      = ext_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    stop_d     = stop_q;
    under_d    = under_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    status_d   = status_q;
    done_d     = 1'b0;
    take       = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          ext_d   = req_ext_i;
          addr_d  = req_addr_i;
          last_d  = IdxW'(req_ext_i) + IdxW'(req_len_i);
          dout_d  = {~req_write_i, (req_len_i > LenW'(1)),
                     (req_ext_i ? 6'h2F : req_addr_i[5:0])};
          stop_d  = 1'b0;
          under_d = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        dout_d  = nxt_byte;
        take    = nxt_take;
        under_d = under_q | nxt_under;
        stop_d  = (last_q == '0);
        k_d     = '0;
        state_d = StWait;
      end
      StWait: begin
        if (spi_load_next_i) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        if (k_q == '0) begin
          status_d = spi_din_i;
        end
        if (!write_q && (k_q >= data_first)) begin
          rd_data_d  = spi_din_i;
          rd_valid_d = 1'b1;
        end
        if (k_q == last_q) begin
          state_d = StDrain;
        end else begin
          dout_d  = nxt_byte;
          take    = nxt_take;
          under_d = under_q | nxt_under;
          stop_d  = ((k_q + IdxW'(1)) == last_q);
          k_d     = k_q + IdxW'(1);
          state_d = StWait;
        end
      end
      StDrain: begin
        if (!spi_busy_i) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      k_q        <= '0;
      last_q     <= '0;
      write_q    <= 1'b0;
      ext_q      <= 1'b0;
      addr_q     <= 8'h00;
      dout_q     <= 8'h00;
      stop_q     <= 1'b0;
      under_q    <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      status_q   <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      last_q     <= last_d;
      write_q    <= write_d;
      ext_q      <= ext_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      stop_q     <= stop_d;
      under_q    <= under_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      status_q   <= status_d;
      done_q     <= done_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign busy_o         = (state_q != StIdle);
  assign spi_start_o    = (state_q == StStart);
  assign wr_take_o      = take;
  assign spi_dout_o     = dout_q;
  assign spi_stop_o     = stop_q;
  assign err_underrun_o = under_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign status_o       = status_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_cc1200_reg_access.sv
// Directed bench for cc1200_reg_access: a behavioural SPI engine and write FIFO around the DUT,
// with hand-computed frame bytes, pulse counts and status values.
module tb_cc1200_reg_access;

  localparam int unsigned LenW = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_write, req_ext;
  logic [7:0]      req_addr;
  logic [LenW-1:0] req_len;
  logic [7:0]      wr_data;
  logic            wr_valid, wr_take;
  logic [7:0]      rd_data, status, spi_dout, spi_din;
  logic            rd_valid, done, busy, err_underrun;
  logic            spi_start, spi_stop, spi_load_next, spi_busy;

  always #5 clk = ~clk;

  cc1200_reg_access #(.LenW(LenW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_write_i     (req_write),
    .req_ext_i       (req_ext),
    .req_addr_i      (req_addr),
    .req_len_i       (req_len),
    .wr_data_i       (wr_data),
    .wr_valid_i      (wr_valid),
    .wr_take_o       (wr_take),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .status_o        (status),
    .done_o          (done),
    .busy_o          (busy),
    .err_underrun_o  (err_underrun),
    .spi_start_o     (spi_start),
    .spi_stop_o      (spi_stop),
    .spi_dout_o      (spi_dout),
    .spi_load_next_i (spi_load_next),
    .spi_din_i       (spi_din),
    .spi_busy_i      (spi_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mosi [0:7];
  logic [7:0] miso [0:7];
  logic [7:0] exp_b [0:7];
  logic [7:0] rd_seen [0:7];
  logic [7:0] wfifo [0:7];
  int w_n, w_ptr;
  int nbytes, stop_idx, n_take, n_rdv, n_done, n_start;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr();
    wr_valid = (w_ptr < w_n);
    wr_data  = wr_valid ? wfifo[w_ptr] : 8'hCC;
  endtask

  // Issue one request and act as the SPI engine: 16-cycle bytes, stop sampled on load_next,
  // MISO byte valid only in the cycle after load_next, spi_busy held 6 cycles past the last byte.
  task automatic run_frame(input logic w, input logic e, input logic [7:0] a,
                           input logic [LenW-1:0] l, input int abort_after);
    int  cnt = 0, pulse_i = 0, tail = 0, din_stage = 0, abort_cnt = -1;
    int  last_pc = -100, done_c = -1;
    bit  started = 0, ended = 0, pop_pend = 0, take_now;
    nbytes = 0; stop_idx = -1; n_take = 0; n_rdv = 0; n_done = 0; n_start = 0; aborted = 0;
    for (int i = 0; i < 8; i++) begin
      mosi[i]    = 'x;
      rd_seen[i] = 'x;
    end
    w_ptr = 0;
    drive_wr();
    req_write = w; req_ext = e; req_addr = a; req_len = l; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("start_lat", spi_start, 1);
    check("err_clr", err_underrun, 0);
    for (int c = 0; c < 800; c++) begin
      take_now = wr_take;
      if (spi_start) begin
        n_start++; mosi[0] = spi_dout; started = 1; cnt = 16; spi_busy = 1'b1;
      end
      if (take_now) n_take++;
      if (rd_valid) begin
        check("rdv_lat", c - last_pc, 2);
        if (n_rdv < 8) rd_seen[n_rdv] = rd_data;
        n_rdv++;
      end
      if (done) begin
        n_done++;
        check("done_ready", {busy, req_ready}, 2'b01);
        if (done_c < 0) done_c = c;
      end
      if (pop_pend) begin
        w_ptr++;
        drive_wr();
        pop_pend = 0;
      end
      if (take_now) pop_pend = 1;
      spi_load_next = 1'b0;
      if (din_stage == 1) begin
        spi_din = miso[pulse_i-1]; din_stage = 2;
      end else if (din_stage == 2) begin
        spi_din = 8'hEE; din_stage = 0;
      end
      if (started && !ended) begin
        cnt--;
        if (cnt == 0) begin
          spi_load_next = 1'b1; last_pc = c;
          if (spi_stop) begin
            ended = 1; stop_idx = pulse_i; nbytes = pulse_i + 1; tail = 6;
          end else if (pulse_i < 7) begin
            mosi[pulse_i+1] = spi_dout;
          end
          pulse_i++; din_stage = 1; cnt = 16;
          if (pulse_i >= 8 && !ended) begin
            ended = 1; tail = 6;
          end
          if (pulse_i == abort_after) abort_cnt = 8;
        end
      end else if (ended && tail > 0) begin
        tail--;
        if (tail == 0) spi_busy = 1'b0;
      end
      if (abort_cnt > 0) begin
        abort_cnt--;
        if (abort_cnt == 0) begin
          aborted = 1;
          break;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      step();
    end
    spi_load_next = 1'b0;
    spi_din = 8'h00;
  endtask

  task automatic check_frame(input int n, input int takes, input int rdvs, input logic [7:0] st);
    check("nbytes", nbytes, n);
    for (int i = 0; i < n; i++) check("mosi", mosi[i], exp_b[i]);
    check("stop_idx", stop_idx, n - 1);
    check("wr_take_cnt", n_take, takes);
    check("rd_valid_cnt", n_rdv, rdvs);
    check("start_cnt", n_start, 1);
    check("done_cnt", n_done, 1);
    check("status", status, st);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", {req_ready, busy, done, rd_valid, wr_take, spi_start, spi_stop,
                      err_underrun}, 8'b1000_0000);
    check("rst_data", {spi_dout, rd_data, status}, 24'h000000);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_ext = 1'b0; req_addr = 8'h00;
    req_len = '0; wr_data = 8'h00; wr_valid = 1'b0; spi_load_next = 1'b0; spi_din = 8'h00;
    spi_busy = 1'b0; w_n = 0; w_ptr = 0;
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Single write 0x10 <- 0xAB
    w_n = 1; wfifo[0] = 8'hAB;
    miso[0] = 8'h5A; miso[1] = 8'h33;
    exp_b[0] = 8'h10; exp_b[1] = 8'hAB;
    run_frame(1'b1, 1'b0, 8'h10, 6'd1, 0);
    check_frame(2, 1, 0, 8'h5A);
    check("err_t1", err_underrun, 0);

    // Extended read of 0x8F
    w_n = 0;
    miso[0] = 8'h0F; miso[1] = 8'h00; miso[2] = 8'h20;
    exp_b[0] = 8'hAF; exp_b[1] = 8'h8F; exp_b[2] = 8'h00;
    run_frame(1'b0, 1'b1, 8'h8F, 6'd1, 0);
    check_frame(3, 0, 1, 8'h0F);
    check("rd_ext", rd_seen[0], 8'h20);

    // SRES strobe
    miso[0] = 8'h7F;
    exp_b[0] = 8'h30;
    run_frame(1'b1, 1'b0, 8'h30, 6'd0, 0);
    check_frame(1, 0, 0, 8'h7F);
    check("err_strobe", err_underrun, 0);

    // Burst write 0x00 <- 11 22 33
    w_n = 3; wfifo[0] = 8'h11; wfifo[1] = 8'h22; wfifo[2] = 8'h33;
    miso[0] = 8'h1F; miso[1] = 8'h01; miso[2] = 8'h02; miso[3] = 8'h03;
    exp_b[0] = 8'h40; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33;
    run_frame(1'b1, 1'b0, 8'h00, 6'd3, 0);
    check_frame(4, 3, 0, 8'h1F);
    check("err_burst", err_underrun, 0);

    // Burst write of 2 bytes with only one byte available: second goes out as 0x00
    w_n = 1; wfifo[0] = 8'h11;
    miso[0] = 8'h2F; miso[1] = 8'h04; miso[2] = 8'h05;
    exp_b[0] = 8'h45; exp_b[1] = 8'h11; exp_b[2] = 8'h00;
    run_frame(1'b1, 1'b0, 8'h05, 6'd2, 0);
    check_frame(3, 1, 0, 8'h2F);
    check("err_under", err_underrun, 1);

    // Next accept clears the sticky underrun (also checked right after accept)
    w_n = 0;
    miso[0] = 8'h22; miso[1] = 8'h99;
    exp_b[0] = 8'h81; exp_b[1] = 8'h00;
    run_frame(1'b0, 1'b0, 8'h01, 6'd1, 0);
    check_frame(2, 0, 1, 8'h22);
    check("rd_single", rd_seen[0], 8'h99);
    check("err_cleared", err_underrun, 0);

    // Reset between the 2nd and 3rd load_next of a 4-byte burst read
    miso[0] = 8'h3C; miso[1] = 8'h41; miso[2] = 8'h42; miso[3] = 8'h43;
    run_frame(1'b0, 1'b0, 8'h3D, 6'd3, 2);
    check("aborted", aborted, 1);
    check("abort_hdr", mosi[0], 8'hFD);
    rst = 1'b1; spi_busy = 1'b0; spi_load_next = 1'b0;
    step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Fresh burst read after the reset
    miso[0] = 8'h11; miso[1] = 8'h44; miso[2] = 8'h55;
    exp_b[0] = 8'hCA; exp_b[1] = 8'h00; exp_b[2] = 8'h00;
    run_frame(1'b0, 1'b0, 8'h0A, 6'd2, 0);
    check_frame(3, 0, 2, 8'h11);
    check("rd_b0", rd_seen[0], 8'h44);
    check("rd_b1", rd_seen[1], 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
